// File: rtl/if_id_stage.sv
// Fetch-to-decode stage: 2-entry skid buffer with immediate-extension pre-decode,
// flush and sticky HALT blocking. Optional id_illegal output under IFID_ILLEGAL_CHECK_EN.
module if_id_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc_inc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_inc,
  output logic [2:0]  id_ext_sel,
  input  logic        id_ready,
  input  logic        flush,
`ifdef IFID_ILLEGAL_CHECK_EN
  output logic        id_illegal,
`endif
  output logic        halted
);

  // Handshake: a word transfers on an edge where valid & ready are both high;
  // if_ready depends on state only, id_* stay stable while id_valid & ~id_ready.

  function automatic logic [2:0] f_ext_sel(input logic [4:0] op);
    logic [2:0] sel;
    sel = 3'b000;
    casez (op)
      5'b10010:                             sel = 3'b001;
      5'b01000, 5'b01001, 5'b100??:         sel = 3'b010;
      5'b01010, 5'b01011, 5'b101??:         sel = 3'b000;
      5'b011??, 5'b11000, 5'b00101, 5'b00111: sel = 3'b100;
      5'b00100, 5'b00110:                   sel = 3'b110;
      default:                              sel = 3'b000;
    endcase
    return sel;
  endfunction

  logic        r_main_valid;
  logic [15:0] r_main_instr;
  logic [15:0] r_main_pc_inc;
  logic [2:0]  r_main_ext_sel;
  logic        r_skid_valid;
  logic [15:0] r_skid_instr;
  logic [15:0] r_skid_pc_inc;
  logic [2:0]  r_skid_ext_sel;
  logic        r_halted;

  logic       w_accept;
  logic       w_main_free;
  logic       w_main_from_skid;
  logic       w_main_from_in;
  logic       w_skid_from_in;
  logic [2:0] w_in_ext_sel;

  assign if_ready         = ~r_skid_valid & ~r_halted;
  assign w_accept         = if_valid & if_ready;
  assign w_main_free      = ~r_main_valid | id_ready;
  assign w_main_from_skid = ~flush & w_main_free & r_skid_valid;
  assign w_main_from_in   = ~flush & w_main_free & ~r_skid_valid & w_accept;
  // A valid skid implies if_ready=0, so skid only ever fills behind a held main.
  assign w_skid_from_in   = ~flush & w_accept & ~w_main_free;
  assign w_in_ext_sel     = f_ext_sel(if_instr[15:11]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid   <= 1'b0;
      r_main_instr   <= NOP_INSTR;
      r_main_pc_inc  <= 16'h0000;
      r_main_ext_sel <= 3'b000;
      r_skid_valid   <= 1'b0;
      r_skid_instr   <= NOP_INSTR;
      r_skid_pc_inc  <= 16'h0000;
      r_skid_ext_sel <= 3'b000;
      r_halted       <= 1'b0;
    end else if (flush) begin
      r_main_valid   <= 1'b0;
      r_main_instr   <= NOP_INSTR;
      r_main_pc_inc  <= 16'h0000;
      r_main_ext_sel <= 3'b000;
      r_skid_valid   <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      if (w_accept && (if_instr[15:11] == 5'b00000)) begin
        r_halted <= 1'b1;
      end
      if (w_main_free) begin
        r_main_valid <= r_skid_valid | w_accept;
      end
      if (w_main_from_skid) begin
        r_main_instr   <= r_skid_instr;
        r_main_pc_inc  <= r_skid_pc_inc;
        r_main_ext_sel <= r_skid_ext_sel;
        r_skid_valid   <= 1'b0;
      end else if (w_main_from_in) begin
        r_main_instr   <= if_instr;
        r_main_pc_inc  <= if_pc_inc;
        r_main_ext_sel <= w_in_ext_sel;
      end
      if (w_skid_from_in) begin
        r_skid_valid   <= 1'b1;
        r_skid_instr   <= if_instr;
        r_skid_pc_inc  <= if_pc_inc;
        r_skid_ext_sel <= w_in_ext_sel;
      end
    end
  end

`ifdef IFID_ILLEGAL_CHECK_EN
  logic r_main_illegal;
  logic r_skid_illegal;
  logic w_in_illegal;

  // Opcodes 111xx carry no ISA assignment.
  assign w_in_illegal = (if_instr[15:13] == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_illegal <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else if (flush) begin
      r_main_illegal <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_main_from_skid) begin
        r_main_illegal <= r_skid_illegal;
      end else if (w_main_from_in) begin
        r_main_illegal <= w_in_illegal;
      end
      if (w_skid_from_in) begin
        r_skid_illegal <= w_in_illegal;
      end
    end
  end

  assign id_illegal = r_main_illegal;
`endif

  assign id_valid   = r_main_valid;
  assign id_instr   = r_main_instr;
  assign id_pc_inc  = r_main_pc_inc;
  assign id_ext_sel = r_main_ext_sel;
  assign halted     = r_halted;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed stimulus with hand-computed expectations,
// expected-queue scoreboard popped by a monitor on each decode-side transfer.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        if_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_inc;
  logic [2:0]  id_ext_sel;
  logic        id_ready;
  logic        flush;
  logic        halted;
`ifdef IFID_ILLEGAL_CHECK_EN
  logic        id_illegal;
`endif

  if_id_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc_inc  (if_pc_inc),
    .if_ready   (if_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc_inc  (id_pc_inc),
    .id_ext_sel (id_ext_sel),
    .id_ready   (id_ready),
    .flush      (flush),
`ifdef IFID_ILLEGAL_CHECK_EN
    .id_illegal (id_illegal),
`endif
    .halted     (halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [34:0] exp_q[$];

  // hand-decoded opcode table: instruction and its expected ext_sel
  logic [15:0] tbl_instr [14] = '{16'h4100, 16'h4800, 16'h8000, 16'h9000, 16'h5000,
                                  16'hA000, 16'h6000, 16'hC000, 16'h2800, 16'h3800,
                                  16'h3000, 16'h0800, 16'hE800, 16'h9800};
  logic [2:0]  tbl_ext   [14] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b000,
                                  3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
                                  3'b110, 3'b000, 3'b000, 3'b010};

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [2:0] ext, input logic rdy, input logic fl,
                       input logic exp_acc);
    @(posedge clk);
    #1;
    if_valid  = v;
    if_instr  = ins;
    if_pc_inc = pc;
    id_ready  = rdy;
    flush     = fl;
    if (v) chk("if_ready", {34'd0, if_ready}, {34'd0, exp_acc});
    if (v && exp_acc && !fl) exp_q.push_back({ins, pc, ext});
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 16'h0000, 16'h0000, 3'b000, rdy, 1'b0, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready && !flush) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {id_instr, id_pc_inc, id_ext_sel}, 35'h7_FFFF_FFFF);
      end else begin
        chk("id_word", {id_instr, id_pc_inc, id_ext_sel}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 16'h0; if_pc_inc = 16'h0;
    id_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_id_valid", {34'd0, id_valid}, 35'd0);
    chk("rst_id_instr", {19'd0, id_instr}, {19'd0, 16'h0800});
    chk("rst_id_pc_ext", {16'd0, id_pc_inc, id_ext_sel}, 35'd0);
    chk("rst_halted", {34'd0, halted}, 35'd0);
    chk("rst_if_ready", {34'd0, if_ready}, 35'd1);
    rst_n = 1'b1;

    // single word, one-cycle latency
    drive(1'b1, 16'h4123, 16'h0002, 3'b010, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t1_valid", {34'd0, id_valid}, 35'd1);
    chk("t1_word", {id_instr, id_pc_inc, id_ext_sel}, {16'h4123, 16'h0002, 3'b010});

    // fill both entries, then drain in order
    drive(1'b1, 16'hC0FF, 16'h0010, 3'b100, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h2005, 16'h0012, 3'b110, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("full_if_ready", {34'd0, if_ready}, 35'd0);
    chk("held_word", {id_instr, id_pc_inc, id_ext_sel}, {16'hC0FF, 16'h0010, 3'b100});
    idle(1'b0);
    chk("held_stable", {id_instr, id_pc_inc, id_ext_sel}, {16'hC0FF, 16'h0010, 3'b100});
    idle(1'b1);
    idle(1'b1);
    chk("drain_if_ready", {34'd0, if_ready}, 35'd1);
    idle(1'b1);
    chk("drain_empty", {34'd0, id_valid}, 35'd0);

    // streaming 20 words, no gaps after the first
    base = n_pop;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, tbl_instr[i % 14] | 16'(i), 16'h0100 + 16'(2 * i), tbl_ext[i % 14],
            1'b1, 1'b0, 1'b1);
      if (i > 0) chk("stream_no_gap", {34'd0, id_valid}, 35'd1);
    end
    idle(1'b1);
    idle(1'b1);
    chk("stream_count", 35'(n_pop - base), 35'd20);

    // flush with both entries full and an incoming word
    drive(1'b1, 16'h1111, 16'h0200, 3'b000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h6222, 16'h0202, 3'b100, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h5333, 16'h0204, 3'b000, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    exp_q.delete();
    chk("flush_valid", {34'd0, id_valid}, 35'd0);
    chk("flush_instr", {19'd0, id_instr}, {19'd0, 16'h0800});
    chk("flush_if_ready", {34'd0, if_ready}, 35'd1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // HALT blocks fetch until flush
    drive(1'b1, 16'h0000, 16'h0300, 3'b000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h4100, 16'h0302, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("halt_set", {34'd0, halted}, 35'd1);
    idle(1'b1);
    idle(1'b1);
    chk("halt_still", {34'd0, halted}, 35'd1);
    drive(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("halt_cleared", {34'd0, halted}, 35'd0);
    chk("halt_if_ready", {34'd0, if_ready}, 35'd1);

    // asynchronous reset between edges
    drive(1'b1, 16'h8888, 16'h0400, 3'b010, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h9999, 16'h0402, 3'b010, 1'b0, 1'b0, 1'b1);
    if_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {34'd0, id_valid}, 35'd0);
    chk("arst_instr", {19'd0, id_instr}, {19'd0, 16'h0800});
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    drive(1'b1, 16'h4123, 16'h0500, 3'b010, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    chk("queue_drained", 35'(exp_q.size()), 35'd0);
    chk("total_outputs", 35'(n_pop), 35'd25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-to-decode pipeline stage of the 16-bit core. It accepts fetched instructions from the fetch unit through a valid/ready handshake and buffers them in a 2-entry skid register. It pre-decodes the 3-bit immediate-extension select, so the decode-stage extender and register file see registered, aligned values. It also handles pipeline flush and HALT blocking.

Parameters:
NOP_INSTR, 16'h0800, instruction word loaded on reset/flush (opcode 00001 = NOP)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_instr  in  16  fetched instruction word
if_pc_inc  in  16  PC+2 of that instruction
if_ready  out  1  stage can accept this cycle
id_valid  out  1  id_* outputs hold a live instruction
id_instr  out  16  instruction to decode
id_pc_inc  out  16  PC+2 paired with id_instr
id_ext_sel  out  3  immediate-extension select for decode extender
id_ready  in  1  decode consumes id_* this cycle
flush  in  1  squash all buffered instructions (branch/jump redirect)
halted  out  1  sticky: HALT captured, fetch blocked

Behaviour:
- Storage: main entry (drives id_*) and skid entry; each holds instr, pc_inc, ext_sel and valid.
- Reset (async, rst_n=0): both entries invalid; id_instr=NOP_INSTR; id_pc_inc=0; id_ext_sel=000; id_valid=0; halted=0.
- if_ready = ~skid.valid & ~halted (combinational from state only; no path from if_valid or id_ready).
- Accept = if_valid & if_ready. Latency: the accepted word appears on id_* on the next cycle at the earliest.
- Consume = id_valid & id_ready.
- Per-edge priority:
  - flush: both entries invalidated; main loaded with NOP_INSTR, pc_inc 0, ext_sel 000; halted cleared; any simultaneous accept is dropped.
  - else if main is empty or consumed: main takes the skid entry if valid, otherwise the incoming accept. A skid entry moving to main frees the skid to take a simultaneous accept.
  - else if main is held (valid & ~id_ready) and an accept occurs: the word goes to skid.
- Ordering is strictly FIFO; no instruction is lost or duplicated under any mix of if_valid and id_ready.
- Both entries full: if_ready=0. Held outputs remain stable while id_valid & ~id_ready.
- HALT: if_instr[15:11]=00000 accepted → halted=1 on the same edge. The HALT word still flows to decode. No further accepts until flush or reset.
- ext_sel is decoded from if_instr[15:11] at accept time and stored with the entry:
  - 01000, 01001, 100xx (ST/LD/STU) → 010 (sign-extend 5)
  - 01010, 01011, 101xx → 000 (zero-extend 5)
  - 10010 → 001 (zero-extend 8)
  - 011xx, 11000, 00101, 00111 → 100 (sign-extend 8)
  - 00100, 00110 → 110 (sign-extend 11)
  - all others → 000
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.

Optional Feature:
Macro IFID_ILLEGAL_CHECK_EN.
- Defined: adds output id_illegal (1 bit), registered with each entry. It is set when the opcode has no ISA assignment (11100–11111, excluding defined ops) and is 0 on reset and flush. An illegal instruction still flows normally.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset, then if_valid=1, if_instr=16'h4123 (ADDI), id_ready=1 → next cycle id_valid=1, id_instr=16'h4123, id_ext_sel=010.
- id_ready=0, push 16'hC0FF then 16'h2005 → if_ready=0 after 2nd accept. Raise id_ready → C0FF (ext_sel 100), then 2005 (ext_sel 110), in order; if_ready returns to 1.
- Streaming: if_valid=1 and id_ready=1 every cycle for 20 words → 20 outputs, in order, one per cycle, no gaps after the first.
- Both entries full, assert flush with if_valid=1 → next cycle id_valid=0, id_instr=16'h0800, if_ready=1; flushed and incoming words never appear.
- Accept 16'h0000 (HALT) → halted=1, if_ready=0, HALT delivered; flush → halted=0.
- Drop rst_n mid-stream between clock edges → id_valid=0 and id_instr=16'h0800 immediately.
